// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one memory port shared by the IF and MEM stages.
// Optional macro ARB_RR_EN: round-robin on collisions instead of data priority.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ready,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT_I = 2'd1,
        S_GRANT_D = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    // Last counter value before the wait budget runs out.
    localparam logic [7:0] LP_TLAST = 8'(TIMEOUT - 1);

    state_t                r_state;
    state_t                w_next;
    logic [7:0]            r_cnt;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;
    logic                  r_if_ready;
    logic                  r_d_ready;
    logic                  r_err;
    logic                  w_any;
    logic                  w_pick_d;
    logic                  w_grant;
    logic                  w_busy;
    logic                  w_ack;
    logic                  w_tmo;
    logic                  w_done;

`ifdef ARB_RR_EN
    logic r_last_d;

    assign w_pick_d = d_req && (!if_req || !r_last_d);

    // Remember which requester won the most recent grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_d <= 1'b0;
        end else if (w_grant) begin
            r_last_d <= w_pick_d;
        end
    end
`else
    // MEM holds the older instruction, so data always wins.
    assign w_pick_d = d_req;
`endif

    assign w_any   = if_req | d_req;
    assign w_grant = (r_state == S_IDLE) && w_any;
    assign w_busy  = (r_state == S_GRANT_I) || (r_state == S_GRANT_D);
    assign w_ack   = w_busy && mem_ack;
    // A late ack in the last allowed cycle still completes normally.
    assign w_tmo   = w_busy && !mem_ack && (r_cnt == LP_TLAST);
    assign w_done  = w_ack || w_tmo;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_next = w_pick_d ? S_GRANT_D : S_GRANT_I;
                end
            end
            S_GRANT_I, S_GRANT_D: begin
                if (w_done) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Wait counter: cleared on grant, counts GRANT cycles without ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (w_grant) begin
            r_cnt <= 8'd0;
        end else if (w_busy && !w_done) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Memory port: launched on grant, held until ack or timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_grant) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= w_pick_d & d_we;
            r_mem_addr <= w_pick_d ? d_addr : if_addr;
            if (w_pick_d) begin
                r_mem_wdata <= d_wdata;
            end
        end else if (w_done) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
        end
    end

    // One-cycle ready and error pulses, coincident with RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_if_ready <= w_done && (r_state == S_GRANT_I);
            r_d_ready  <= w_done && (r_state == S_GRANT_D);
            r_err      <= w_tmo;
        end
    end

    // Read data capture; stores keep the old load data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else if (w_done) begin
            if (r_state == S_GRANT_I) begin
                r_if_rdata <= w_ack ? mem_rdata : '0;
            end
            if ((r_state == S_GRANT_D) && (w_tmo || !r_mem_we)) begin
                r_d_rdata <= w_ack ? mem_rdata : '0;
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign if_ready  = r_if_ready;
    assign d_rdata   = r_d_rdata;
    assign d_ready   = r_d_ready;
    assign err       = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: transaction-scheduled reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_mem_port_arbiter;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        err;

    mem_port_arbiter #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    // requester agents
    bit          a_if_pend = 0;
    logic [31:0] a_if_a = '0;
    bit          a_d_pend = 0;
    bit          a_d_w = 0;
    logic [31:0] a_d_a = '0;
    logic [31:0] a_d_wd = '0;

    // transaction-level model: one access scheduled at a time
    bit          m_act = 0;
    int          m_g = 0;
    int          m_len = 0;
    int          m_lat = 0;
    bit          m_tmo = 0;
    bit          m_win_d = 0;
    bit          m_we = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wd = '0;
    int          m_free = 0;
    logic [31:0] e_if_rdata = '0;
    logic [31:0] e_d_rdata = '0;

    bit          rnd_en = 0;
    bit          rst_cmd = 1;
    int          lat_q[$];
    logic [31:0] dat_q[$];

    // observed-event recorders for the literal checks
    bit prev_mreq = 0;
    int t_rise0, t_rise1, t_ifr, t_dr, t_err, n_mreq;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, a, e);
        end
    endtask

    task automatic clr_rec();
        t_rise0 = -1; t_rise1 = -1; t_ifr = -1;
        t_dr = -1; t_err = -1; n_mreq = 0;
    endtask

    task automatic step();
        bit e_mreq, e_ifr, e_dr, e_err;
        @(negedge clk);
        cyc++;
        e_mreq = m_act && cyc >= m_g + 1 && cyc <= m_g + m_len;
        e_ifr  = m_act && cyc == m_g + m_len + 1 && !m_win_d;
        e_dr   = m_act && cyc == m_g + m_len + 1 && m_win_d;
        e_err  = m_act && cyc == m_g + m_len + 1 && m_tmo;
        chk("mem_req", 32'(mem_req), 32'(e_mreq));
        chk("if_ready", 32'(if_ready), 32'(e_ifr));
        chk("d_ready", 32'(d_ready), 32'(e_dr));
        chk("err", 32'(err), 32'(e_err));
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("d_rdata", d_rdata, e_d_rdata);
        if (e_mreq) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", 32'(mem_we), 32'(m_we));
            if (m_we) chk("mem_wdata", mem_wdata, m_wd);
        end
        if (rst) begin
            chk("rst_mem_addr", mem_addr, 32'h0);
            chk("rst_mem_wdata", mem_wdata, 32'h0);
            chk("rst_mem_we", 32'(mem_we), 32'h0);
        end
        if (mem_req && !prev_mreq) begin
            if (t_rise0 < 0) t_rise0 = cyc;
            else if (t_rise1 < 0) t_rise1 = cyc;
        end
        prev_mreq = mem_req;
        if (mem_req) n_mreq++;
        if (if_ready && t_ifr < 0) t_ifr = cyc;
        if (d_ready && t_dr < 0) t_dr = cyc;
        if (err && t_err < 0) t_err = cyc;
        // requesters drop on their ready and may re-request at once
        if (e_ifr) a_if_pend = 0;
        if (e_dr) a_d_pend = 0;
        if (rnd_en && !rst_cmd) begin
            if (!a_if_pend && $urandom % 3 == 0) begin
                a_if_pend = 1; a_if_a = $urandom;
            end
            if (!a_d_pend && $urandom % 3 == 0) begin
                a_d_pend = 1; a_d_w = 1'($urandom % 2);
                a_d_a = $urandom; a_d_wd = $urandom;
            end
        end
        if (rst_cmd && !rst) begin
            rst = 1'b1;
            #1;
            chk("rst_now_mem_req", 32'(mem_req), 32'h0);
            chk("rst_now_ready", 32'({if_ready, d_ready}), 32'h0);
        end else begin
            rst = rst_cmd;
        end
        if (rst_cmd) begin
            m_act = 0; m_free = 0;
            e_if_rdata = '0; e_d_rdata = '0;
        end else if (cyc >= m_free && (a_if_pend || a_d_pend)) begin
            m_act   = 1;
            m_win_d = a_d_pend;
            m_g     = cyc;
            m_addr  = m_win_d ? a_d_a : a_if_a;
            m_we    = m_win_d && a_d_w;
            m_wd    = a_d_wd;
            if (lat_q.size() > 0) m_lat = lat_q.pop_front();
            else if ($urandom % 8 == 0) m_lat = $urandom_range(TMO + 3, TMO - 2);
            else m_lat = $urandom_range(4, 1);
            m_tmo  = m_lat > TMO;
            m_len  = m_tmo ? TMO : m_lat;
            m_free = m_g + m_len + 2;
        end
        // memory responder driven from the schedule; stray acks elsewhere
        mem_rdata = $urandom;
        if (!rst_cmd && m_act && cyc >= m_g + 1 && cyc <= m_g + m_len) begin
            mem_ack = (cyc == m_g + m_lat);
            if (mem_ack) begin
                if (dat_q.size() > 0) mem_rdata = dat_q.pop_front();
                if (!m_win_d) e_if_rdata = mem_rdata;
                else if (!m_we) e_d_rdata = mem_rdata;
            end else if (cyc == m_g + m_len) begin
                if (m_win_d) e_d_rdata = '0;
                else e_if_rdata = '0;
            end
        end else begin
            mem_ack = ($urandom % 4 == 0);
        end
        if_req = a_if_pend; if_addr = a_if_a;
        d_req = a_d_pend; d_we = a_d_w;
        d_addr = a_d_a; d_wdata = a_d_wd;
    endtask

    task automatic run_idle();
        int k;
        k = 0;
        while ((cyc + 1 < m_free || a_if_pend || a_d_pend) && k < 300) begin
            step();
            k++;
        end
        if (k >= 300) begin
            n_vec++; n_bad++;
            $display("FAIL idle_bound cycle %0d: got busy expected idle", cyc);
        end
    endtask

    int s;

    initial begin
        clr_rec();
        repeat (3) step();
        chk("rst_if_rdata", if_rdata, 32'h0);
        rst_cmd = 0;
        step();

        // fetch alone
        run_idle(); clr_rec(); s = cyc + 1;
        a_if_pend = 1; a_if_a = 32'h40;
        lat_q.push_back(1); dat_q.push_back(32'h2010000A);
        run_idle(); step();
        chk("A_rise", 32'(t_rise0), 32'(s + 1));
        chk("A_nreq", 32'(n_mreq), 32'd1);
        chk("A_ifready", 32'(t_ifr), 32'(s + 2));
        chk("A_rdata", if_rdata, 32'h2010000A);

        // collision: data first, fetch 3 cycles later
        run_idle(); clr_rec(); s = cyc + 1;
        a_if_pend = 1; a_if_a = 32'h44;
        a_d_pend = 1; a_d_w = 0; a_d_a = 32'h80;
        lat_q.push_back(1); lat_q.push_back(1);
        dat_q.push_back(32'h11112222); dat_q.push_back(32'h33334444);
        run_idle(); step();
        chk("B_rise_d", 32'(t_rise0), 32'(s + 1));
        chk("B_rise_i", 32'(t_rise1), 32'(s + 4));
        chk("B_dready", 32'(t_dr), 32'(s + 2));
        chk("B_ifready", 32'(t_ifr), 32'(s + 5));
        chk("B_drdata", d_rdata, 32'h11112222);
        chk("B_ifrdata", if_rdata, 32'h33334444);

        // store with ack delayed 4 cycles
        run_idle(); clr_rec(); s = cyc + 1;
        a_d_pend = 1; a_d_w = 1; a_d_a = 32'h10; a_d_wd = 32'hDEADBEEF;
        lat_q.push_back(4);
        run_idle(); step();
        chk("C_nreq", 32'(n_mreq), 32'd4);
        chk("C_dready", 32'(t_dr), 32'(s + 5));
        chk("C_drdata", d_rdata, 32'h11112222);

        // timeout, then ack in the last allowed cycle
        run_idle(); clr_rec(); s = cyc + 1;
        a_d_pend = 1; a_d_w = 0; a_d_a = 32'h20;
        lat_q.push_back(99);
        run_idle(); step();
        chk("D_nreq", 32'(n_mreq), 32'd15);
        chk("D_err", 32'(t_err), 32'(s + 16));
        chk("D_dready", 32'(t_dr), 32'(s + 16));
        chk("D_drdata", d_rdata, 32'h0);
        run_idle(); clr_rec(); s = cyc + 1;
        a_d_pend = 1;
        lat_q.push_back(TMO); dat_q.push_back(32'h55556666);
        run_idle(); step();
        chk("D2_nreq", 32'(n_mreq), 32'd15);
        chk("D2_err", 32'(t_err), 32'hFFFFFFFF);
        chk("D2_dready", 32'(t_dr), 32'(s + 16));
        chk("D2_drdata", d_rdata, 32'h55556666);

        // reset during GRANT_D with a fetch held
        run_idle(); clr_rec();
        a_d_pend = 1; a_d_a = 32'h30;
        a_if_pend = 1; a_if_a = 32'h50;
        lat_q.push_back(99);
        repeat (3) step();
        rst_cmd = 1; a_d_pend = 0;
        repeat (3) step();
        clr_rec();
        rst_cmd = 0;
        lat_q.push_back(1);
        step(); s = cyc;
        run_idle(); step();
        chk("E_rise", 32'(t_rise0), 32'(s + 1));
        chk("E_ifready", 32'(t_ifr), 32'(s + 2));
        chk("E_no_dready", 32'(t_dr), 32'hFFFFFFFF);

        // randomized traffic with occasional resets
        rnd_en = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom % 700 == 0) begin
                rst_cmd = 1; a_if_pend = 0; a_d_pend = 0;
                repeat (2) step();
                rst_cmd = 0;
            end
            step();
        end
        rnd_en = 0;
        run_idle();
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
